// File: rtl/fat32_pkg.sv
// Shared FAT32 constants: FAT entry marks, sector geometry and the BPB/MBR
// byte offsets used by the boot-sector parsers, plus the sector-builder states.
package fat32_pkg;

    localparam logic [31:0] FAT_EOC         = 32'h0FFF_FFFF;
    localparam logic [31:0] FAT_MEDIA       = 32'h0FFF_FFF8;
    localparam logic [31:0] FAT_FREE        = 32'h0000_0000;
    localparam logic [31:0] FAT_MAX_CLUSTER = 32'h0FFF_FFEF;
    localparam logic [31:0] FAT_ENTRY_MASK  = 32'h0FFF_FFFF;

    localparam int SECTOR_BYTES       = 512;
    localparam int ENTRIES_PER_SECTOR = SECTOR_BYTES / 4;

    localparam int BPB_RSVD_SEC_CNT_OFS = 'h00E;
    localparam int BPB_NUM_FATS_OFS     = 'h010;
    localparam int BPB_FAT_SZ32_OFS     = 'h024;
    localparam int MBR_PART0_LBA_OFS    = 'h1C6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CALC,
        ST_EMIT,
        ST_FIN,
        ST_ERR
    } fsm_state_e;

endpackage

// File: rtl/fat32_entry_value.sv
// Value of one FAT32 entry for cluster c_i when the only allocated chain is
// first_i..last_i; the top nibble is reserved and always written as zero.
module fat32_entry_value
    import fat32_pkg::*;
(
    input  logic [31:0] c_i,
    input  logic [31:0] first_i,
    input  logic [32:0] last_i,
    input  logic        count_nz_i,
    output logic [31:0] value_o
);
    logic [32:0] c_wide;
    logic [31:0] raw;

    assign c_wide = {1'b0, c_i};

    always_comb begin
        raw = FAT_FREE;
        if (c_i == 32'd0) begin
            raw = FAT_MEDIA;
        end else if (c_i == 32'd1) begin
            raw = FAT_EOC;
        end else if (count_nz_i && (c_i >= first_i) && (c_wide < last_i)) begin
            raw = c_i + 32'd1;
        end else if (count_nz_i && (c_wide == last_i)) begin
            raw = FAT_EOC;
        end
    end

    assign value_o = raw & FAT_ENTRY_MASK;

endmodule

// File: rtl/fat32_fat_sector_builder.sv
// Streams one 512-byte FAT32 FAT sector for a single contiguous cluster chain
// as little-endian address/data/strobe bytes into the sector RAM.
//   state | meaning
//   IDLE  | waiting for start
//   CHECK | validate latched request, compute last cluster
//   CALC  | register value of entry i
//   EMIT  | present byte k of entry i until wrReady
//   FIN   | done pulse
//   ERR   | done pulse with error, nothing written
module fat32_fat_sector_builder
    import fat32_pkg::*;
(
    input  logic        Clock,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [31:0] fatSectorIndex,
    input  logic [31:0] firstCluster,
    input  logic [31:0] clusterCount,
    input  logic        wrReady,
    output logic [8:0]  writeAddress,
    output logic [7:0]  EditByte,
    output logic        InputOrOutput,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam logic [6:0] LAST_ENTRY = 7'(ENTRIES_PER_SECTOR - 1);

    fsm_state_e  state_q, state_d;
    logic [31:0] index_q, index_d;
    logic [31:0] first_q, first_d;
    logic [31:0] count_q, count_d;
    logic [32:0] last_q, last_d, last_sum;
    logic [6:0]  entry_q, entry_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] value_q, value_d;
    logic        error_q, error_d;
    logic [31:0] cluster, entry_value;
    logic        reject;

    // 33-bit sum so a chain wrapping past 2^32 is still caught as out of range
    assign last_sum = {1'b0, first_q} + {1'b0, count_q} - 33'd1;
    assign reject   = (first_q < 32'd2) ||
                      ((count_q != 32'd0) && (last_sum > {1'b0, FAT_MAX_CLUSTER}));
    assign cluster  = (index_q * 32'(ENTRIES_PER_SECTOR)) + {25'd0, entry_q};

    fat32_entry_value u_entry_value (
        .c_i        (cluster),
        .first_i    (first_q),
        .last_i     (last_q),
        .count_nz_i (count_q != 32'd0),
        .value_o    (entry_value)
    );

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            first_q <= '0;
            count_q <= '0;
            last_q  <= '0;
            entry_q <= '0;
            byte_q  <= '0;
            value_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            first_q <= first_d;
            count_q <= count_d;
            last_q  <= last_d;
            entry_q <= entry_d;
            byte_q  <= byte_d;
            value_q <= value_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        first_d = first_q;
        count_d = count_q;
        last_d  = last_q;
        entry_d = entry_q;
        byte_d  = byte_q;
        value_d = value_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d = fatSectorIndex;
                    first_d = firstCluster;
                    count_d = clusterCount;
                    error_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                last_d  = last_sum;
                entry_d = '0;
                if (reject) begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                value_d = entry_value;
                byte_d  = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (wrReady) begin
                    if (byte_q != 2'd3) begin
                        byte_d = byte_q + 2'd1;
                    end else if (entry_q != LAST_ENTRY) begin
                        entry_d = entry_q + 7'd1;
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign InputOrOutput = (state_q == ST_EMIT);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN) || (state_q == ST_ERR);
    assign error         = error_q;
    assign writeAddress  = InputOrOutput ? {entry_q, byte_q} : 9'd0;
    assign EditByte      = InputOrOutput ? value_q[{byte_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_fat32_fat_sector_builder.sv
// Bench for fat32_fat_sector_builder: directed and randomized sector requests
// compared against an arithmetic model of the FAT entry rules.
module tb_fat32_fat_sector_builder;

    logic        Clock = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [31:0] fatSectorIndex;
    logic [31:0] firstCluster;
    logic [31:0] clusterCount;
    logic        wrReady;
    logic [8:0]  writeAddress;
    logic [7:0]  EditByte;
    logic        InputOrOutput;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_b [512];
    logic [7:0] cap_b [512];

    fat32_fat_sector_builder dut (
        .Clock          (Clock),
        .sys_rst_n      (sys_rst_n),
        .start          (start),
        .fatSectorIndex (fatSectorIndex),
        .firstCluster   (firstCluster),
        .clusterCount   (clusterCount),
        .wrReady        (wrReady),
        .writeAddress   (writeAddress),
        .EditByte       (EditByte),
        .InputOrOutput  (InputOrOutput),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint model_entry(longint c, longint first, longint count);
        longint last;
        last = first + count - 1;
        if (c == 0) return 64'h0FFF_FFF8;
        if (c == 1) return 64'h0FFF_FFFF;
        if (count != 0 && c >= first && c < last) return (c + 1) & 64'h0FFF_FFFF;
        if (count != 0 && c == last) return 64'h0FFF_FFFF;
        return 0;
    endfunction

    function automatic bit model_reject(longint first, longint count);
        return (first < 2) || (count != 0 && (first + count - 1) > 64'h0FFF_FFEF);
    endfunction

    task automatic build_expected(input logic [31:0] idx, input logic [31:0] first,
                                  input logic [31:0] count);
        longint c, v;
        for (int i = 0; i < 128; i++) begin
            c = (longint'(idx) * 128 + i) & 64'hFFFF_FFFF;
            v = model_entry(c, longint'(first), longint'(count));
            for (int k = 0; k < 4; k++) exp_b[i*4 + k] = 8'((v >> (8*k)) & 8'hFF);
        end
    endtask

    function automatic logic [31:0] cap_entry(int i);
        return {cap_b[i*4+3], cap_b[i*4+2], cap_b[i*4+1], cap_b[i*4]};
    endfunction

    // mode: 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready
    task automatic run_sector(input logic [31:0] idx, input logic [31:0] first,
                              input logic [31:0] count, input int mode,
                              input int repulse_at, input int abort_at);
        int  n, cyc, done_cyc, last_xfer, first_cyc;
        bit  rdy, finished, aborted, rej;
        rej = model_reject(longint'(first), longint'(count));
        build_expected(idx, first, count);
        for (int i = 0; i < 512; i++) cap_b[i] = 8'hxx;
        n = 0; done_cyc = -1; last_xfer = -1; first_cyc = -1;
        finished = 0; aborted = 0;
        fatSectorIndex = idx; firstCluster = first; clusterCount = count;
        start = 1'b1;
        @(negedge Clock);
        cyc = 1;
        while (!finished && cyc < 3000) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            wrReady = rdy;
            start = (cyc == repulse_at);
            fatSectorIndex = $urandom; firstCluster = $urandom; clusterCount = $urandom;
            chk("busy", busy, 1'b1);
            chk("error_live", error, rej && cyc >= 2);
            if (InputOrOutput) begin
                chk("write_overrun", n < 512, 1'b1);
                if (n < 512) begin
                    chk("addr", writeAddress, n);
                    chk("data", EditByte, exp_b[n]);
                    if (first_cyc < 0) first_cyc = cyc;
                    if (rdy) begin
                        cap_b[n] = EditByte;
                        n++;
                        last_xfer = cyc;
                    end
                end
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1;
            end
            if (abort_at > 0 && n == abort_at) begin
                sys_rst_n = 1'b0;
                #1;
                chk("abort_io", InputOrOutput, 1'b0);
                chk("abort_addr", writeAddress, 9'd0);
                chk("abort_data", EditByte, 8'd0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_error", error, 1'b0);
                repeat (4) begin
                    @(negedge Clock);
                    chk("abort_no_done", done, 1'b0);
                end
                sys_rst_n = 1'b1;
                aborted = 1;
                break;
            end
            @(negedge Clock);
            cyc++;
        end
        start = 1'b0;
        wrReady = 1'b1;
        if (!aborted) begin
            chk("timeout", finished, 1'b1);
            chk("xfer_count", n, rej ? 0 : 512);
            chk("done_cycle", done_cyc, rej ? 2 : last_xfer + 1);
            if (mode == 0 && !rej) begin
                chk("latency_done", done_cyc, 642);
                chk("latency_first", first_cyc, 3);
            end
            repeat (3) begin
                chk("post_done", done, 1'b0);
                chk("post_io", InputOrOutput, 1'b0);
                chk("post_busy", busy, 1'b0);
                chk("post_error", error, rej);
                @(negedge Clock);
            end
        end
    endtask

    initial begin
        logic [31:0] f, cnt, idx;
        sys_rst_n = 1'b0; start = 1'b0; wrReady = 1'b1;
        fatSectorIndex = '0; firstCluster = '0; clusterCount = '0;
        #1;
        chk("rst_io", InputOrOutput, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_addr", writeAddress, 9'd0);
        chk("rst_data", EditByte, 8'd0);
        repeat (3) @(negedge Clock);
        sys_rst_n = 1'b1;
        @(negedge Clock);

        run_sector(32'd0, 32'd2, 32'd3, 0, -1, 0);
        chk("s0_e0", cap_entry(0), 32'h0FFF_FFF8);
        chk("s0_e1", cap_entry(1), 32'h0FFF_FFFF);
        chk("s0_e2", cap_entry(2), 32'h0000_0003);
        chk("s0_e3", cap_entry(3), 32'h0000_0004);
        chk("s0_e4", cap_entry(4), 32'h0FFF_FFFF);
        chk("s0_e5", cap_entry(5), 32'h0000_0000);

        run_sector(32'd1, 32'd120, 32'd20, 0, -1, 0);
        chk("s1_e0", cap_entry(0), 32'h0000_0081);
        chk("s1_e10", cap_entry(10), 32'h0000_008B);
        chk("s1_e11", cap_entry(11), 32'h0FFF_FFFF);
        chk("s1_e12", cap_entry(12), 32'h0000_0000);

        run_sector(32'd0, 32'd2, 32'd3, 1, -1, 0);
        run_sector(32'd0, 32'd1, 32'd5, 0, -1, 0);
        run_sector(32'd0, 32'd2, 32'd0, 0, 100, 0);
        chk("empty_e2", cap_entry(2), 32'h0000_0000);
        run_sector(32'd0, 32'd2, 32'd300, 0, -1, 200);
        run_sector(32'd0, 32'd2, 32'd300, 0, -1, 0);
        run_sector(32'd0, 32'h0FFF_FFF0, 32'd1, 0, -1, 0);

        for (int t = 0; t < 6; t++) begin
            idx = $urandom_range(0, 4);
            f   = $urandom_range(0, 700);
            cnt = $urandom_range(0, 400);
            run_sector(idx, f, cnt, 2, -1, 0);
        end
        for (int t = 0; t < 3; t++) begin
            f   = 32'h0FFF_FF80 + $urandom_range(0, 127);
            cnt = $urandom_range(0, 140);
            idx = f >> 7;
            run_sector(idx, f, cnt, 2, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
